// File: rtl/trap_ctrl.sv
// Trap sequencer: prioritises exceptions/mret, pulses the CSR file, redirects fetch,
// and parks the core in lockup on trap storms. Optional interrupt path: TRAP_CTRL_IRQ_EN.
module trap_ctrl #(
  parameter int unsigned TRAP_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid,
  input  logic        exc_fetch_misalign,
  input  logic        exc_illegal,
  input  logic        exc_ebreak,
  input  logic        exc_ecall,
  input  logic        exc_load_misalign,
  input  logic        exc_store_misalign,
  input  logic        mret_req,
  input  logic        retire,
  input  logic [31:0] pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
`ifdef TRAP_CTRL_IRQ_EN
  input  logic        mie,
  input  logic        irq,
`endif
  output logic        trap,
  output logic [4:0]  trap_cause,
  output logic [31:0] epc,
  output logic        ret,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        lockup
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAP,
    S_RET,
    S_REDIRECT,
    S_LOCKUP
  } state_t;

  localparam logic [8:0] LIMIT = 9'(TRAP_LIMIT);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        trap_q;
  logic [4:0]  cause_q;
  logic [31:0] epc_q;
  logic        ret_q;
  logic        redir_q;
  logic [31:0] redir_pc_q;
  logic        busy_q;
  logic        lockup_q;

  logic        exc_any;
  logic [3:0]  exc_code;
  logic        irq_take;
  logic        hits_limit;

  always_comb begin
    exc_any  = exc_fetch_misalign | exc_illegal | exc_ebreak | exc_ecall |
               exc_load_misalign | exc_store_misalign;
    exc_code = 4'd0;
    if (exc_fetch_misalign)      exc_code = 4'd0;
    else if (exc_illegal)        exc_code = 4'd2;
    else if (exc_ebreak)         exc_code = 4'd3;
    else if (exc_ecall)          exc_code = 4'd11;
    else if (exc_load_misalign)  exc_code = 4'd4;
    else if (exc_store_misalign) exc_code = 4'd6;
`ifdef TRAP_CTRL_IRQ_EN
    irq_take = exc_valid & irq & mie;
`else
    irq_take = 1'b0;
`endif
    hits_limit = (({1'b0, cnt_q} + 9'd1) == LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      trap_q     <= 1'b0;
      cause_q    <= '0;
      epc_q      <= '0;
      ret_q      <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      busy_q     <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      // Pulse outputs default low; payloads are zero whenever their strobe is low.
      trap_q     <= 1'b0;
      cause_q    <= '0;
      epc_q      <= '0;
      ret_q      <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (irq_take) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 5'b1_1011;
            epc_q   <= pc;
            busy_q  <= 1'b1;
          end else if (exc_valid && exc_any) begin
            cnt_q  <= cnt_q + 8'd1;
            busy_q <= 1'b1;
            if (hits_limit) begin
              state_q  <= S_LOCKUP;
              lockup_q <= 1'b1;
            end else begin
              state_q <= S_TRAP;
              trap_q  <= 1'b1;
              cause_q <= {1'b0, exc_code};
              epc_q   <= pc;
            end
          end else if (exc_valid && mret_req) begin
            state_q <= S_RET;
            ret_q   <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (retire) begin
            cnt_q <= '0;
          end
        end
        S_TRAP: begin
          state_q    <= S_REDIRECT;
          redir_q    <= 1'b1;
          redir_pc_q <= mtvec & ~32'd3;
        end
        S_RET: begin
          state_q    <= S_REDIRECT;
          redir_q    <= 1'b1;
          redir_pc_q <= mepc & ~32'd3;
        end
        S_REDIRECT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_LOCKUP: begin
          busy_q   <= 1'b1;
          lockup_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign epc         = epc_q;
  assign ret         = ret_q;
  assign redirect    = redir_q;
  assign redirect_pc = redir_pc_q;
  assign busy        = busy_q;
  assign lockup      = lockup_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: table of transactions plus hand sequences; expected output
// frames are queued per cycle and compared on the falling edge.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid;
  logic        exc_fetch_misalign, exc_illegal, exc_ebreak, exc_ecall;
  logic        exc_load_misalign, exc_store_misalign;
  logic        mret_req, retire;
  logic [31:0] pc, mtvec, mepc;
`ifdef TRAP_CTRL_IRQ_EN
  logic        mie, irq;
`endif
  logic        trap, ret, redirect, busy, lockup;
  logic [4:0]  trap_cause;
  logic [31:0] epc, redirect_pc;

  trap_ctrl #(.TRAP_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .exc_valid(exc_valid),
    .exc_fetch_misalign(exc_fetch_misalign), .exc_illegal(exc_illegal),
    .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall),
    .exc_load_misalign(exc_load_misalign), .exc_store_misalign(exc_store_misalign),
    .mret_req(mret_req), .retire(retire), .pc(pc), .mtvec(mtvec), .mepc(mepc),
`ifdef TRAP_CTRL_IRQ_EN
    .mie(mie), .irq(irq),
`endif
    .trap(trap), .trap_cause(trap_cause), .epc(epc), .ret(ret),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy), .lockup(lockup)
  );

  always #5 clk = ~clk;

  typedef enum int {K_TRAP, K_RET, K_IDLE, K_LOCK} kind_e;

  // exc bit order: fetch, illegal, ebreak, ecall, load, store
  typedef struct {
    logic        valid;
    logic [5:0]  exc;
    logic        mret;
    logic        retire;
    logic [31:0] pc;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    kind_e       kind;
    logic [4:0]  cause;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    int          due;
    logic [73:0] v;
  } frame_t;

  frame_t sb[$];
  frame_t fr;
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  vec_t   tbl[12];

  localparam logic [5:0] E_ECALL = 6'b000100;

  always @(posedge clk) cyc++;

  function automatic logic [73:0] pk(logic t, logic [4:0] c, logic [31:0] e, logic r,
                                     logic rd, logic [31:0] rp, logic b, logic l);
    return {t, c, e, r, rd, rp, b, l};
  endfunction

  function automatic vec_t mk(logic valid, logic [5:0] exc, logic mret, logic rt,
                              logic [31:0] p, logic [31:0] tv, logic [31:0] ep,
                              kind_e kind, logic [4:0] cause, logic [31:0] rpc);
    vec_t v;
    v.valid = valid; v.exc = exc; v.mret = mret; v.retire = rt;
    v.pc = p; v.mtvec = tv; v.mepc = ep; v.kind = kind; v.cause = cause; v.rpc = rpc;
    return v;
  endfunction

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      fr = sb.pop_front();
      checks++;
      if (fr.due != cyc ||
          {trap, trap_cause, epc, ret, redirect, redirect_pc, busy, lockup} !== fr.v) begin
        errors++;
        $display("FAIL out_frame cyc=%0d due=%0d got={trap,cause,epc,ret,redir,rpc,busy,lock}=%h required=%h",
                 cyc, fr.due,
                 {trap, trap_cause, epc, ret, redirect, redirect_pc, busy, lockup}, fr.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int due, logic [73:0] v);
    frame_t f;
    f.due = due;
    f.v   = v;
    sb.push_back(f);
  endtask

  task automatic set_exc(logic [5:0] e);
    {exc_fetch_misalign, exc_illegal, exc_ebreak, exc_ecall,
     exc_load_misalign, exc_store_misalign} = e;
  endtask

  task automatic clr();
    exc_valid = 1'b0;
    set_exc(6'b0);
    mret_req  = 1'b0;
    retire    = 1'b0;
  endtask

  task automatic do_vec(vec_t v);
    int k;
    exc_valid = v.valid;
    set_exc(v.exc);
    mret_req  = v.mret;
    retire    = v.retire;
    pc        = v.pc;
    mtvec     = v.mtvec;
    mepc      = v.mepc;
    k = cyc;
    case (v.kind)
      K_TRAP: begin
        push(k + 1, pk(1'b1, v.cause, v.pc, 1'b0, 1'b0, '0, 1'b1, 1'b0));
        push(k + 2, pk(1'b0, '0, '0, 1'b0, 1'b1, v.rpc, 1'b1, 1'b0));
        push(k + 3, '0);
      end
      K_RET: begin
        push(k + 1, pk(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0));
        push(k + 2, pk(1'b0, '0, '0, 1'b0, 1'b1, v.rpc, 1'b1, 1'b0));
        push(k + 3, '0);
      end
      K_IDLE: push(k + 1, '0);
      default: push(k + 1, pk(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1));
    endcase
    tick();
    clr();
    if (v.kind == K_TRAP || v.kind == K_RET) begin
      tick();
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push(cyc + 1, '0);
    tick();
    rst_n = 1'b1;
    clr();
    push(cyc + 1, '0);
    tick();
  endtask

  task automatic ecall(logic [31:0] p, logic rt, kind_e kind);
    do_vec(mk(1'b1, E_ECALL, 1'b0, rt, p, 32'h0000_0104, 32'h0, kind, 5'd11, 32'h0000_0104));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required finish before time limit", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1, 6'b000100, 0, 0, 32'h100, 32'h4,        32'h0,   K_TRAP, 5'd11, 32'h4);
    tbl[1]  = mk(1, 6'b010010, 1, 0, 32'h204, 32'h8,        32'h0,   K_TRAP, 5'd2,  32'h8);
    tbl[2]  = mk(1, 6'b000000, 1, 0, 32'h208, 32'h8,        32'h203, K_RET,  5'd0,  32'h200);
    tbl[3]  = mk(1, 6'b000100, 0, 0, 32'h300, 32'h1003,     32'h0,   K_TRAP, 5'd11, 32'h1000);
    tbl[4]  = mk(1, 6'b111111, 1, 1, 32'h404, 32'h80,       32'h0,   K_TRAP, 5'd0,  32'h80);
    tbl[5]  = mk(1, 6'b001111, 0, 0, 32'h508, 32'h82,       32'h0,   K_TRAP, 5'd3,  32'h80);
    tbl[6]  = mk(0, 6'b000000, 0, 1, 32'h50c, 32'h82,       32'h0,   K_IDLE, 5'd0,  32'h0);
    tbl[7]  = mk(1, 6'b000011, 0, 0, 32'h60c, 32'h100,      32'h0,   K_TRAP, 5'd4,  32'h100);
    tbl[8]  = mk(1, 6'b000001, 0, 0, 32'h710, 32'h100,      32'h0,   K_TRAP, 5'd6,  32'h100);
    tbl[9]  = mk(0, 6'b000100, 1, 0, 32'h714, 32'h100,      32'h9,   K_IDLE, 5'd0,  32'h0);
    tbl[10] = mk(1, 6'b000000, 0, 1, 32'h718, 32'h100,      32'h0,   K_IDLE, 5'd0,  32'h0);
    tbl[11] = mk(1, 6'b011000, 0, 0, 32'h800, 32'hffff_fffe, 32'h0,  K_TRAP, 5'd2,  32'hffff_fffc);

    rst_n = 1'b0;
    clr();
    pc = '0; mtvec = '0; mepc = '0;
`ifdef TRAP_CTRL_IRQ_EN
    irq = 1'b0; mie = 1'b0;
`endif
    tick();
    tick();
    push(cyc + 1, '0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) do_vec(tbl[i]);

    // Trap storm; retire alongside the first trap must not clear the count.
    do_reset();
    ecall(32'h10, 1'b1, K_TRAP);
    ecall(32'h14, 1'b0, K_TRAP);
    ecall(32'h18, 1'b0, K_TRAP);
    ecall(32'h1c, 1'b0, K_LOCK);
    for (int i = 0; i < 8; i++) begin
      exc_valid = 1'b1;
      set_exc(6'($urandom));
      mret_req  = 1'($urandom);
      retire    = 1'($urandom);
      pc        = $urandom;
      push(cyc + 1, pk(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1));
      tick();
    end
    clr();
    do_reset();

    // mret clears the count: three more traps fit afterwards.
    ecall(32'h20, 1'b0, K_TRAP);
    ecall(32'h24, 1'b0, K_TRAP);
    do_vec(mk(1, 6'b0, 1, 0, 32'h28, 32'h104, 32'h3ff, K_RET, 5'd0, 32'h3fc));
    ecall(32'h2c, 1'b0, K_TRAP);
    ecall(32'h30, 1'b0, K_TRAP);
    ecall(32'h34, 1'b0, K_TRAP);
    do_reset();

    // Reset during TRAP: no redirect follows.
    exc_valid = 1'b1; set_exc(E_ECALL); pc = 32'h40; mtvec = 32'h104;
    push(cyc + 1, pk(1'b1, 5'd11, 32'h40, 1'b0, 1'b0, '0, 1'b1, 1'b0));
    tick();
    clr();
    rst_n = 1'b0;
    push(cyc + 1, '0);
    tick();
    rst_n = 1'b1;
    push(cyc + 1, '0);
    tick();
    ecall(32'h44, 1'b0, K_TRAP);

    // Reset during REDIRECT.
    exc_valid = 1'b1; set_exc(E_ECALL); pc = 32'h48;
    push(cyc + 1, pk(1'b1, 5'd11, 32'h48, 1'b0, 1'b0, '0, 1'b1, 1'b0));
    tick();
    clr();
    push(cyc + 1, pk(1'b0, '0, '0, 1'b0, 1'b1, 32'h104, 1'b1, 1'b0));
    tick();
    rst_n = 1'b0;
    push(cyc + 1, '0);
    tick();
    rst_n = 1'b1;
    push(cyc + 1, '0);
    tick();
    ecall(32'h4c, 1'b0, K_TRAP);

`ifdef TRAP_CTRL_IRQ_EN
    // Interrupts win over exceptions and leave the storm counter alone.
    do_reset();
    irq = 1'b1; mie = 1'b1;
    for (int i = 0; i < 3; i++)
      do_vec(mk(1, E_ECALL, 0, 0, 32'h40, 32'h104, 32'h0, K_TRAP, 5'b11011, 32'h104));
    mie = 1'b0;
    ecall(32'h40, 1'b0, K_TRAP);
    ecall(32'h44, 1'b0, K_TRAP);
    ecall(32'h48, 1'b0, K_TRAP);
    irq = 1'b0;
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
